rr_arb4_stage: RTL and testbench

- Round-robin arbiter and register stage for four upstream channels.
- It picks one valid channel per transfer and produces the 2-bit select that steers the downstream 4:1 selector.
- It registers the selected data word, its select code and a valid flag for the consumer.
- Fairness: after a channel is served, it has the lowest priority on the next arbitration.

---
 rtl/rr_arb4_stage.sv | 100 ++++++++++
 tb/tb_rr_arb4_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arb4_stage.sv
// rr_arb4_stage: round-robin arbiter plus output register for four upstream
// channels. One valid channel is granted per transfer. The granted word, its
// 2-bit channel index and a valid flag are registered for the consumer.
// A served channel drops to the lowest priority for the next arbitration.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   per-channel request (bit i = channel i)
//   in_data    channel i at [i*WIDTH +: WIDTH]
//   in_ready   one-hot grant (or zero); combinational, gated by rst
//   out_valid  output register holds a word
//   out_data   registered word of the granted channel
//   out_sel    registered index (0..3) of that channel
//   out_ready  consumer takes the held word this cycle
module rr_arb4_stage #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         in_valid,
   input  logic [4*WIDTH-1:0] in_data,
   output logic [3:0]         in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [1:0]         out_sel,
   input  logic               out_ready
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic [1:0]       sel_q,   sel_d;
   logic [1:0]       last_q,  last_d;

   logic       load;
   logic       found;
   logic [1:0] grant;

   // Register can take a word when empty or being drained this cycle.
   assign load = !valid_q || out_ready;

   // Search last+1 .. last+4 (mod 4); the first requester wins.
   always_comb begin
      logic [1:0] idx;
      found = 1'b0;
      grant = '0;
      idx   = '0;
      for (int unsigned k = 1; k <= 4; k++) begin
         idx = last_q + 2'(k);
         if (!found && in_valid[idx]) begin
            found = 1'b1;
            grant = idx;
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (!rst && load && found) begin
         in_ready[grant] = 1'b1;
      end
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      sel_d   = sel_q;
      last_d  = last_q;
      if (load) begin
         if (found) begin
            valid_d = 1'b1;
            data_d  = in_data[grant*WIDTH +: WIDTH];
            sel_d   = grant;
            last_d  = grant;
         end else begin
            // Drain without refill: data/sel keep their stale value.
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sel_q   <= '0;
         last_q  <= 2'd3;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_arb4_stage.sv
// tb_rr_arb4_stage: directed and randomized checks of rr_arb4_stage against a
// transaction-level reference model (priority search with integer mod-4).
module tb_rr_arb4_stage;

   localparam int W = 8;

   logic           clk;
   logic           rst;
   logic [3:0]     in_valid;
   logic [4*W-1:0] in_data;
   logic [3:0]     in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [1:0]     out_sel;
   logic           out_ready;

   int n_cmp;
   int n_err;

   // reference model state
   int           m_last;
   bit           m_valid;
   logic [W-1:0] m_data;
   int           m_sel;

   rr_arb4_stage #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pick(input int last, input logic [3:0] req);
      for (int k = 1; k <= 4; k++) begin
         if (req[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_last  = 3;
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
   endtask

   task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check1({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
         check1({tag, ".out_data"}, 32'(out_data), 32'(m_data));
         check1({tag, ".out_sel"},  32'(out_sel),  32'(m_sel));
      end
   endtask

   // One clock: check combinational grant before the edge, advance the model
   // on the edge, then check the registered outputs.
   task automatic cycle(input string tag);
      bit         load;
      int         g;
      logic [3:0] exp_rdy;
      #2;
      load    = !m_valid || out_ready;
      g       = pick(m_last, in_valid);
      exp_rdy = '0;
      if (load && g >= 0) exp_rdy[g] = 1'b1;
      check1({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
      @(posedge clk);
      if (load) begin
         if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[g*W +: W];
            m_sel   = g;
            m_last  = g;
         end else begin
            m_valid = 1'b0;
         end
      end
      #1;
      check_outputs(tag);
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst       = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      check1("reset.in_ready", 32'(in_ready), 32'h0);
      rst = 1'b0;

      // Full round-robin from reset: 0,1,2,3,0,1,2,3
      in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle("rr");
         check1("rr.sel_const", 32'(out_sel), 32'(i % 4));
      end

      // Fairness skip: set last=1, then 1001 grants 3 then 0
      in_valid = 4'b0010;
      cycle("skip.setup");
      in_valid = 4'b1001;
      #2 check1("skip.rdy3", 32'(in_ready), 32'h8);
      cycle("skip.a");
      #2 check1("skip.rdy0", 32'(in_ready), 32'h1);
      cycle("skip.b");

      // Backpressure: 3 stalled cycles, then release
      in_valid  = 4'b0110;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) cycle("stall");
      out_ready = 1'b1;
      cycle("stall.release");

      // Drain to empty with a single word on channel 2
      in_valid = 4'b0000;
      cycle("drain.empty");
      in_valid = 4'b0100;
      in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
      cycle("drain.load");
      check1("drain.sel2", 32'(out_sel), 32'd2);
      in_valid = 4'b0000;
      cycle("drain.out");
      check1("drain.valid0", 32'(out_valid), 32'd0);
      in_valid = 4'b0100;
      cycle("drain.again");

      // Lone requester: no bubbles
      in_valid = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         in_data = {$urandom};
         cycle("lone");
         check1("lone.valid", 32'(out_valid), 32'd1);
      end

      // Reset mid-stall while holding a word
      in_valid  = 4'b1111;
      out_ready = 1'b0;
      cycle("prestall");
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      check1("arst.out_valid", 32'(out_valid), 32'd0);
      check1("arst.out_data",  32'(out_data),  32'd0);
      check1("arst.out_sel",   32'(out_sel),   32'd0);
      check1("arst.in_ready",  32'(in_ready),  32'd0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      cycle("arst.first");
      check1("arst.first_sel", 32'(out_sel), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         in_valid  = 4'($urandom_range(0, 15));
         in_data   = {$urandom};
         out_ready = ($urandom_range(0, 3) != 0);
         cycle("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
